// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with a 2-bit direction counter per entry.
// Lookup is combinational on fetch_PC; training happens on the clock edge from the
// execute-stage update bundle.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   fetch_PC                   PC being fetched
//   predict_taken, predict_PC  next-PC prediction
//   keep                       pipeline hold, blocks training
//   flush                      invalidate the whole table
//   upd_valid, upd_PC, upd_taken, upd_target, upd_miss
//                              resolved-branch report from execute
// Optional macro BTB_PERF_EN adds btb_update_count, btb_taken_count and
// btb_miss_count, which count accepted training edges.
module branch_target_buffer #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_PC,
   output logic        predict_taken,
   output logic [31:0] predict_PC,
   input  logic        keep,
   input  logic        flush,
   input  logic        upd_valid,
   input  logic [31:0] upd_PC,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_miss
`ifdef BTB_PERF_EN
   ,
   output logic [31:0] btb_update_count,
   output logic [31:0] btb_taken_count,
   output logic [31:0] btb_miss_count
`endif
);
   localparam int ENTRIES = 2**INDEX_W;
   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic [31:0]      target_d [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];
   logic [1:0]       ctr_d    [ENTRIES];
   logic [INDEX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0]   f_tag, u_tag;
   logic               hit, u_hit, accept, misaligned;
   logic [1:0]         u_ctr;
   assign f_idx = fetch_PC[INDEX_W+1:2];
   assign f_tag = fetch_PC[31:INDEX_W+2];
   assign u_idx = upd_PC[INDEX_W+1:2];
   assign u_tag = upd_PC[31:INDEX_W+2];
   // Lookup sees pre-edge contents only; there is no write-to-read bypass.
   assign hit           = valid_q[f_idx] && tag_q[f_idx] == f_tag;
   assign predict_taken = hit && ctr_q[f_idx][1];
   assign predict_PC    = predict_taken ? target_q[f_idx] : fetch_PC + 32'd4;
   assign u_hit      = valid_q[u_idx] && tag_q[u_idx] == u_tag;
   assign u_ctr      = ctr_q[u_idx];
   assign accept     = upd_valid && !keep && !flush;
   assign misaligned = upd_target[1:0] != 2'b00;
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
            ctr_d[i]   = 2'b01;
         end
      end else if (accept) begin
         // A misaligned target takes the exception path: drop any existing entry
         // for this branch and never allocate one.
         if (misaligned) begin
            valid_d[u_idx] = valid_q[u_idx] && !u_hit;
         end else if (u_hit) begin
            ctr_d[u_idx] = upd_taken ? (u_ctr == 2'b11 ? u_ctr : u_ctr + 2'd1)
                                     : (u_ctr == 2'b00 ? u_ctr : u_ctr - 2'd1);
            if (upd_taken) target_d[u_idx] = upd_target;
         end else if (upd_taken) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = upd_target;
            ctr_d[u_idx]    = 2'b10;
         end
      end
   end
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
      end
   end
`ifdef BTB_PERF_EN
   logic [31:0] update_cnt_q, update_cnt_d;
   logic [31:0] taken_cnt_q, taken_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   always_comb begin
      update_cnt_d = accept ? update_cnt_q + 32'd1 : update_cnt_q;
      taken_cnt_d  = accept ? taken_cnt_q + {31'd0, upd_taken} : taken_cnt_q;
      miss_cnt_d   = accept ? miss_cnt_q + {31'd0, upd_miss} : miss_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         update_cnt_q <= '0;
         taken_cnt_q  <= '0;
         miss_cnt_q   <= '0;
      end else begin
         update_cnt_q <= update_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end
   assign btb_update_count = update_cnt_q;
   assign btb_taken_count  = taken_cnt_q;
   assign btb_miss_count   = miss_cnt_q;
   logic unused_bits;
   assign unused_bits = ^{fetch_PC[1:0], upd_PC[1:0]};
`else
   logic unused_bits;
   assign unused_bits = ^{fetch_PC[1:0], upd_PC[1:0], upd_miss};
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer.
module tb_branch_target_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] fetch_PC = '0;
   logic        predict_taken;
   logic [31:0] predict_PC;
   logic        keep = 1'b0;
   logic        flush = 1'b0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_PC = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_miss = 1'b0;
   int checks = 0;
   int failures = 0;
`ifdef BTB_PERF_EN
   logic [31:0] btb_update_count, btb_taken_count, btb_miss_count;
`endif
   branch_target_buffer dut (
      .clk(clk), .rst(rst), .fetch_PC(fetch_PC),
      .predict_taken(predict_taken), .predict_PC(predict_PC),
      .keep(keep), .flush(flush), .upd_valid(upd_valid), .upd_PC(upd_PC),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_miss(upd_miss)
`ifdef BTB_PERF_EN
      , .btb_update_count(btb_update_count), .btb_taken_count(btb_taken_count),
      .btb_miss_count(btb_miss_count)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask
   task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic miss);
      upd_valid = 1'b1; upd_PC = pc; upd_taken = tk; upd_target = tgt; upd_miss = miss;
      step();
      upd_valid = 1'b0;
   endtask
   task automatic fetch(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc);
      fetch_PC = pc;
      #1;
      check({tag, "_t"}, {31'd0, predict_taken}, {31'd0, exp_t});
      check({tag, "_pc"}, predict_PC, exp_pc);
   endtask
`ifdef BTB_PERF_EN
   task automatic perf(input string tag, input int u, input int t, input int m);
      check({tag, "_upd"}, btb_update_count, u);
      check({tag, "_tkn"}, btb_taken_count, t);
      check({tag, "_mis"}, btb_miss_count, m);
   endtask
`endif
   initial begin
      do_rst();
      fetch("rst", 32'h100, 1'b0, 32'h104);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      fetch("alloc", 32'h100, 1'b1, 32'h200);
      fetch("tag_miss", 32'h1100, 1'b0, 32'h1104);
      train(32'h100, 1'b0, 32'h0, 1'b0);
      fetch("ctr01", 32'h100, 1'b0, 32'h104);
      train(32'h100, 1'b0, 32'h0, 1'b0);
      train(32'h100, 1'b0, 32'h0, 1'b0);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      fetch("low_sat", 32'h100, 1'b0, 32'h104);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      fetch("ctr10", 32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      fetch("high_sat", 32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b0, 32'h0, 1'b0);
      fetch("ctr11_10", 32'h100, 1'b1, 32'h200);
      train(32'h100, 1'b0, 32'h0, 1'b0);
      fetch("ctr10_01", 32'h100, 1'b0, 32'h104);
      train(32'h100, 1'b1, 32'h280, 1'b0);
      fetch("new_target", 32'h100, 1'b1, 32'h280);
      train(32'h700, 1'b0, 32'h800, 1'b0);
      fetch("no_alloc_nt", 32'h700, 1'b0, 32'h704);
      train(32'h180, 1'b1, 32'h203, 1'b0);
      fetch("no_alloc_mis", 32'h180, 1'b0, 32'h184);
      train(32'h100, 1'b1, 32'h202, 1'b0);
      fetch("misalign_inv", 32'h100, 1'b0, 32'h104);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      fetch("realloc", 32'h100, 1'b1, 32'h200);
      fetch("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
      fetch_PC = 32'h500;
      upd_valid = 1'b1; upd_PC = 32'h500; upd_taken = 1'b1; upd_target = 32'h600;
      #1;
      check("no_bypass_pc", predict_PC, 32'h504);
      step();
      upd_valid = 1'b0;
      fetch("post_edge", 32'h500, 1'b1, 32'h600);
      do_rst();
      fetch("rst2", 32'h100, 1'b0, 32'h104);
`ifdef BTB_PERF_EN
      perf("perf_rst", 0, 0, 0);
`endif
      upd_valid = 1'b1; upd_PC = 32'h300; upd_taken = 1'b1; upd_target = 32'h400; upd_miss = 1'b1;
      keep = 1'b1;
      repeat (3) step();
      fetch("keep_blocks", 32'h300, 1'b0, 32'h304);
      keep = 1'b0;
      step();
      upd_valid = 1'b0;
      fetch("keep_release", 32'h300, 1'b1, 32'h400);
`ifdef BTB_PERF_EN
      perf("perf_keep", 1, 1, 1);
`endif
      train(32'h300, 1'b0, 32'h0, 1'b0);
      fetch("one_alloc", 32'h300, 1'b0, 32'h304);
      train(32'h100, 1'b1, 32'h200, 1'b0);
      fetch("pre_flush", 32'h100, 1'b1, 32'h200);
      flush = 1'b1;
      train(32'h140, 1'b1, 32'h500, 1'b1);
      flush = 1'b0;
      fetch("flush_100", 32'h100, 1'b0, 32'h104);
      fetch("flush_140", 32'h140, 1'b0, 32'h144);
`ifdef BTB_PERF_EN
      perf("perf_flush", 3, 2, 1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Fetch-side branch predictor that consumes the execute stage's resolved-branch report and supplies the next-PC prediction to the fetch stage.
- Direct-mapped BTB, one 2-bit saturating direction counter per entry.
- Prediction is a combinational lookup on the current fetch PC.
- Training happens on the clock edge from the execute-stage update bundle (branch PC, taken flag, target, mispredict flag).

Parameters:
INDEX_W, 6, index bits; ENTRIES = 2**INDEX_W (64).
TAG_W, 24, tag bits; must equal 30 - INDEX_W.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
fetch_PC  input  32  PC currently being fetched
predict_taken  output  1  1 = fetch should redirect to predict_PC
predict_PC  output  32  predicted next PC
keep  input  1  pipeline hold; suppresses training
flush  input  1  invalidate whole table
upd_valid  input  1  execute stage holds a branch/jump (is_branch)
upd_PC  input  32  PC of that branch
upd_taken  input  1  branch resolved taken
upd_target  input  32  resolved target PC
upd_miss  input  1  execute stage flagged a mispredict (used only by the optional counters)

Behaviour:
Addressing:
- idx = PC[INDEX_W+1:2]; tag = PC[31:INDEX_W+2]; PC[1:0] ignored.

Storage per entry:
- valid (1), tag (TAG_W), target (32), ctr (2).

Reset (rst=1 at an edge):
- All valid=0, all ctr=2'b01.
- Outputs follow from the cleared table: predict_taken=0, predict_PC=fetch_PC+4.

Lookup (combinational, zero latency):
- hit = valid[idx] && tag[idx]==tag(fetch_PC).
- predict_taken = hit && ctr[idx][1].
- predict_PC = predict_taken ? target[idx] : fetch_PC+4.
- Addition is 32-bit modulo, so 0xFFFF_FFFC+4 = 0x0000_0000.

Training (edge, when upd_valid && !keep && !flush):
- u_hit = valid and tag match at idx(upd_PC).
- u_hit && upd_taken:
  - ctr saturating +1 (max 2'b11);
  - target <= upd_target.
- u_hit && !upd_taken: ctr saturating -1 (min 2'b00); target unchanged.
- !u_hit && upd_taken: allocate, overwriting any occupant:
  - valid=1, tag=tag(upd_PC), target=upd_target, ctr=2'b10.
- !u_hit && !upd_taken: no change (no allocation on not-taken).
- Misaligned target (upd_target[1:0]!=0, the exception path): never allocate; if u_hit, clear valid at that idx; ctr untouched.

keep=1:
- Training is blocked, because the execute stage re-presents the same branch while held; one update per resolved branch.
- Lookup is unaffected.

flush=1 at an edge:
- All valid=0, all ctr=2'b01.
- Flush has priority over a simultaneous update, and that update is dropped.

Same-cycle lookup and training on the same idx:
- Lookup returns the pre-edge contents; no write-to-read bypass.

Only the single indexed entry changes per edge, apart from rst/flush.

Optional Feature:
Macro BTB_PERF_EN.
When defined:
- Adds outputs btb_update_count[31:0], btb_taken_count[31:0], btb_miss_count[31:0].
- On each accepted training edge (upd_valid && !keep && !flush):
  - btb_update_count += 1;
  - btb_taken_count += upd_taken;
  - btb_miss_count += upd_miss.
- Counters wrap modulo 2^32.
- rst clears them to 0; flush does not clear them.

When undefined:
- These ports and registers are absent.
- Prediction and training behaviour is identical.

Test Plan:
1. Reset, then fetch_PC=0x0000_0100 -> predict_taken=0, predict_PC=0x0000_0104.
2. Train upd_PC=0x100, taken, target=0x200 (one edge); then fetch 0x100 -> predict_taken=1, predict_PC=0x200 (ctr=10). Fetch 0x1100 (same idx, different tag) -> predict_taken=0, predict_PC=0x1104.
3. After case 2, train 0x100 not-taken twice -> ctr 10->01->00 and fetch 0x100 predicts 0x104. Train taken three times -> ctr reaches 11 and stays at 11 after a 4th taken.
4. Hold upd_valid=1, taken, upd_PC=0x300, target=0x400 with keep=1 for 3 cycles, then keep=0 for 1 cycle -> exactly one allocation (ctr=10). With BTB_PERF_EN: btb_update_count=1.
5. Valid entry at 0x100; assert flush and an update for 0x140 in the same cycle -> both entries invalid afterward; fetch 0x140 -> predict_PC=0x144.
6. Valid entry at 0x100; train 0x100 taken with target 0x202 -> entry invalidated, fetch 0x100 -> predict_PC=0x104. Separately, fetch_PC=0xFFFF_FFFC on an empty table -> predict_PC=0x0000_0000.
